// File: rtl/parser_pkg.sv
// parser_pkg: rule descriptor type, sender FSM encoding and info-type codes shared with the rule receiver
package parser_pkg;
  localparam int TYPE_NUM = 4;
  localparam int KEY_FILED_NUM = 8;
  localparam int TYPE_WIDTH = 16;
  localparam int TYPE_OFFSET_WIDTH = 8;
  localparam int KEY_OFFSET_WIDTH = 8;
  localparam int SHIFT_WIDTH = 8;
  localparam int RULE_CONF_WR_NUM = 2 * TYPE_NUM + KEY_FILED_NUM + 3;
  localparam int IDX_W = 4;
  localparam int TI_W = $clog2(TYPE_NUM);
  localparam int KI_W = $clog2(KEY_FILED_NUM);
  localparam logic [2:0] INFO_COMMIT = 3'd0;
  localparam logic [2:0] INFO_TYPE = 3'd1;
  localparam logic [2:0] INFO_TOFF = 3'd2;
  localparam logic [2:0] INFO_KEY = 3'd3;
  localparam logic [2:0] INFO_HEAD = 3'd4;
  localparam logic [2:0] INFO_META = 3'd5;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] S_TOFF = 3'd2;
  localparam logic [2:0] S_KEY = 3'd3;
  localparam logic [2:0] S_HEAD = 3'd4;
  localparam logic [2:0] S_META = 3'd5;
  localparam logic [2:0] S_COMMIT = 3'd6;
  typedef struct packed {
    logic valid;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0] type_data;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0] type_mask;
    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] type_offset;
    logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0] key_offset;
    logic [KEY_FILED_NUM-1:0] key_offset_v;
    logic [SHIFT_WIDTH-1:0] head_shift;
    logic [SHIFT_WIDTH-1:0] meta_shift;
  } rule_desc_t;
  function automatic logic [2:0] info_code(input logic [2:0] st);
    return st == S_TYPE ? INFO_TYPE : st == S_TOFF ? INFO_TOFF : st == S_KEY ? INFO_KEY :
           st == S_HEAD ? INFO_HEAD : st == S_META ? INFO_META : INFO_COMMIT;
  endfunction
endpackage

// File: rtl/rule_conf_sender_if.sv
// rule_conf_sender_if: descriptor handshake plus rule config write bus; RULE_CONF_SENDER_STAT_EN adds commit_cnt
interface rule_conf_sender_if;
  import parser_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic [5:0] cmd_rule_id;
  rule_desc_t cmd_desc;
  logic hold;
  logic rule_wren;
  logic [31:0] rule_wdata;
  logic [31:0] rule_addr;
  logic busy;
  logic done;
`ifdef RULE_CONF_SENDER_STAT_EN
  logic [15:0] commit_cnt;
  modport master(input cmd_valid, cmd_rule_id, cmd_desc, hold,
                 output cmd_ready, rule_wren, rule_wdata, rule_addr, busy, done, commit_cnt);
  modport slave(output cmd_valid, cmd_rule_id, cmd_desc, hold,
                input cmd_ready, rule_wren, rule_wdata, rule_addr, busy, done, commit_cnt);
`else
  modport master(input cmd_valid, cmd_rule_id, cmd_desc, hold,
                 output cmd_ready, rule_wren, rule_wdata, rule_addr, busy, done);
  modport slave(output cmd_valid, cmd_rule_id, cmd_desc, hold,
                input cmd_ready, rule_wren, rule_wdata, rule_addr, busy, done);
`endif
endinterface

// File: rtl/rule_conf_sender.sv
// rule_conf_sender: streams a rule descriptor as config writes ending in a commit; RULE_CONF_SENDER_STAT_EN adds a commit counter
module rule_conf_sender
  import parser_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int IDLE_GAP = 0
) (
  input logic i_clk,
  input logic i_rst,
  rule_conf_sender_if.master bus
);
  logic [2:0] state_q, state_d, nst;
  logic [IDX_W-1:0] idx_q, idx_d, nix, last_ix;
  logic [1:0] gap_q, gap_d;
  logic [5:0] id_q, id_d;
  rule_desc_t desc_q, desc_d, src;
  logic wren_q, wren_d, done_q, done_d;
  logic [31:0] wdata_q, wdata_d, addr_q, addr_d, word, waddr;
  logic accept, free, seq, step, gap_start, load;
  assign free = !bus.hold;
  assign bus.cmd_ready = state_q == S_IDLE && free;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign bus.busy = state_q != S_IDLE;
  assign bus.rule_wren = wren_q && free;
  assign bus.done = done_q && free;
  assign bus.rule_wdata = wdata_q;
  assign bus.rule_addr = addr_q;
  // successor of the write on the bus and the word it produces
  always_comb begin
    seq = state_q == S_TYPE || state_q == S_TOFF || state_q == S_KEY;
    last_ix = state_q == S_KEY ? IDX_W'(KEY_FILED_NUM - 1) : IDX_W'(TYPE_NUM - 1);
    step = seq && idx_q != last_ix;
    nst = state_q == S_IDLE ? S_TYPE : step ? state_q : state_q == S_COMMIT ? S_IDLE : state_q + 3'd1;
    nix = step ? idx_q + 1'b1 : '0;
    src = state_q == S_IDLE ? bus.cmd_desc : desc_q;
    word = nst == S_TYPE ? (32'(src.type_data[nix[TI_W-1:0]]) << 16) | 32'(src.type_mask[nix[TI_W-1:0]]) :
           nst == S_TOFF ? 32'(src.type_offset[nix[TI_W-1:0]]) :
           nst == S_KEY ? {15'd0, src.key_offset_v[nix[KI_W-1:0]], 16'(src.key_offset[nix[KI_W-1:0]])} :
           nst == S_HEAD ? 32'(src.head_shift) :
           nst == S_META ? 32'(src.meta_shift) :
           nst == S_COMMIT ? 32'(src.valid) : '0;
    waddr = nst == S_IDLE ? '0 : {ADDR_BASE[31:16], 5'd0, info_code(nst), 2'd0,
            nst == S_COMMIT ? id_q : (nst == S_HEAD || nst == S_META) ? 6'd0 : 6'(nix)};
  end
  // one write per free cycle with IDLE_GAP empty cycles between writes; hold freezes everything
  always_comb begin
    gap_start = state_q != S_IDLE && state_q != S_COMMIT && gap_q == 2'd0 && IDLE_GAP != 0;
    load = state_q == S_IDLE ? accept : gap_q == 2'd0 ? !gap_start : gap_q == 2'd1;
    state_d = free && load ? nst : state_q;
    idx_d = free && load ? nix : idx_q;
    gap_d = !free ? gap_q : gap_start ? 2'(IDLE_GAP) : gap_q != 2'd0 ? gap_q - 2'd1 : 2'd0;
    wren_d = free ? load && nst != S_IDLE : wren_q;
    done_d = free ? load && nst == S_COMMIT : done_q;
    wdata_d = free ? (load ? word : '0) : wdata_q;
    addr_d = free ? (load ? waddr : '0) : addr_q;
    desc_d = accept ? bus.cmd_desc : desc_q;
    id_d = accept ? bus.cmd_rule_id : id_q;
  end
  // state and the single output register stage
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      gap_q <= '0;
      id_q <= '0;
      desc_q <= '0;
      wren_q <= 1'b0;
      done_q <= 1'b0;
      wdata_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
      id_q <= id_d;
      desc_q <= desc_d;
      wren_q <= wren_d;
      done_q <= done_d;
      wdata_q <= wdata_d;
      addr_q <= addr_d;
    end
`ifdef RULE_CONF_SENDER_STAT_EN
  logic [15:0] cnt_q, cnt_d;
  // count commit writes that actually reach the bus
  always_comb cnt_d = bus.done ? cnt_q + 16'd1 : cnt_q;
  // commit counter register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign bus.commit_cnt = cnt_q;
`endif
endmodule
